calc_ctrl: RTL and testbench

Sequencing controller for the calculator datapath. It sits between the board buttons and switches, the button encoder that produces the 4-bit ALU opcode, and the 32-bit ALU. It synchronizes and debounces the execute and clear buttons. On each execute press it samples the opcode and switch operand, drives the ALU and waits the ALU latency. It then writes the result back into an accumulator that feeds the next operation and the LEDs.

---
 rtl/calc_ctrl.sv | 138 +++++++++++++
 tb/tb_calc_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl.sv
// Calculator sequencer: debounces execute/clear buttons, issues one ALU
// operation per execute press and writes the result into the accumulator.
module calc_db #(
  parameter int DB_CNT = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic pulse
);
  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  logic [1:0]    sync;
  logic          level, level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync    <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      pulse   <= level & ~level_d;
      // level only moves after DB_CNT consecutive disagreeing samples
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CNT - 1)) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module calc_ctrl #(
  parameter int DB_CNT  = 1000000,
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        btnd,
  input  logic        btnu,
  input  logic [15:0] sw,
  input  logic [3:0]  alu_op_in,
  input  logic [31:0] alu_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [15:0] led,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  localparam logic [3:0] LAT_INIT = (ALU_LAT > 0) ? 4'(ALU_LAT - 1) : 4'd0;

  state_t      state, state_n;
  logic [1:0]  btn_p;
  logic        exec_p, clr_p;
  logic [3:0]  lat_cnt;
  logic [31:0] acc;
  logic        load_op, load_lat, wr_acc;

  calc_db #(.DB_CNT(DB_CNT)) u_db [1:0] (
    .clk    (clk),
    .resetn (resetn),
    .raw    ({btnu, btnd}),
    .pulse  (btn_p)
  );

  assign exec_p = btn_p[0];
  assign clr_p  = btn_p[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // The result is sampled on entry to CAPTURE so it is visible while done is high.
  always_comb begin
    state_n  = state;
    load_op  = 1'b0;
    load_lat = 1'b0;
    wr_acc   = 1'b0;
    if (clr_p) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (exec_p) begin
          state_n = ISSUE;
          load_op = 1'b1;
        end
        ISSUE: if (ALU_LAT == 0) begin
          state_n = CAPTURE;
          wr_acc  = 1'b1;
        end else begin
          state_n  = WAIT;
          load_lat = 1'b1;
        end
        WAIT: if (lat_cnt == 4'd0) begin
          state_n = CAPTURE;
          wr_acc  = 1'b1;
        end
        CAPTURE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc     <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      lat_cnt <= '0;
    end else begin
      if (clr_p)       acc <= '0;
      else if (wr_acc) acc <= alu_result;
      if (load_op) begin
        alu_op <= alu_op_in;
        alu_b  <= {{16{sw[15]}}, sw};
      end
      if (load_lat)           lat_cnt <= LAT_INIT;
      else if (state == WAIT) lat_cnt <= lat_cnt - 4'd1;
    end
  end

  assign alu_a = acc;
  assign led   = acc[15:0];
  assign busy  = (state != IDLE);
  assign done  = (state == CAPTURE) && !clr_p;
endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: three instances (ALU_LAT 1, 3, 0) share button stimulus and
// are compared every cycle against a timeline model of presses and operations.
module tb_calc_ctrl;
  localparam int DB = 4;

  logic clk, resetn, btnd, btnu;
  logic [15:0] sw;
  logic [3:0]  alu_op_in;
  logic [2:0][31:0] alu_a, alu_b, alu_res;
  logic [2:0][3:0]  alu_op;
  logic [2:0][15:0] led;
  logic [2:0]       busy, done;

  int n_chk, n_pass, cyc;
  int done_cnt [3], busy_cyc [3], last_done [3];
  int lat_exp [3] = '{10, 12, 9};

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      default: return b;
    endcase
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 0;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    calc_ctrl #(.DB_CNT(DB), .ALU_LAT(L)) dut (
      .clk(clk), .resetn(resetn), .btnd(btnd), .btnu(btnu), .sw(sw),
      .alu_op_in(alu_op_in), .alu_result(alu_res[g]), .alu_a(alu_a[g]),
      .alu_b(alu_b[g]), .alu_op(alu_op[g]), .led(led[g]), .busy(busy[g]), .done(done[g])
    );
    if (L == 0) begin : g_comb
      assign alu_res[g] = alu_f(alu_op[g], alu_a[g], alu_b[g]);
    end else begin : g_pipe
      logic [31:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= alu_f(alu_op[g], alu_a[g], alu_b[g]);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign alu_res[g] = pipe[L-1];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Reference model: accepted presses become timed operations of length ALU_LAT+2.
  logic [31:0] m_acc [3], m_b [3];
  logic [3:0]  m_op [3];
  logic        m_active [3];
  int          m_start [3];
  logic [1:0]  m_hist [2];
  int          m_run [2], m_rise [2];
  logic        m_lvl [2], m_pulse [2];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = '0; m_b[i] = '0; m_op[i] = '0; m_active[i] = 1'b0; m_start[i] = -100;
    end
    for (int b = 0; b < 2; b++) begin
      m_hist[b] = '0; m_run[b] = 0; m_rise[b] = -100; m_lvl[b] = 1'b0; m_pulse[b] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic ex, cl, s;
    ex = m_pulse[0];
    cl = m_pulse[1];
    for (int i = 0; i < 3; i++) begin
      int j;
      j = cyc - m_start[i];
      if (cl) begin
        m_active[i] = 1'b0;
        m_acc[i] = '0;
      end else if (m_active[i]) begin
        if (j == lat_of(i) + 1) m_acc[i] = alu_f(m_op[i], m_acc[i], m_b[i]);
        if (j == lat_of(i) + 2) m_active[i] = 1'b0;
      end else if (ex) begin
        m_active[i] = 1'b1;
        m_start[i]  = cyc;
        m_op[i]     = alu_op_in;
        m_b[i]      = {{16{sw[15]}}, sw};
      end
    end
    // button level follows the raw value seen two clocks ago once it has disagreed DB times in a row
    for (int b = 0; b < 2; b++) begin
      s = m_hist[b][1];
      m_hist[b] = {m_hist[b][0], (b == 1) ? btnu : btnd};
      if (s == m_lvl[b]) m_run[b] = 0;
      else begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] == DB) begin
          m_run[b] = 0;
          m_lvl[b] = s;
          if (s) m_rise[b] = cyc;
        end
      end
      m_pulse[b] = (cyc == m_rise[b] + 1);
    end
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < 3; i++) begin done_cnt[i] = 0; busy_cyc[i] = 0; last_done[i] = -1; end
    forever begin
      @(posedge clk);
      cyc++;
      if (!resetn) model_reset();
      else model_step();
      @(negedge clk);
      if (resetn) begin
        for (int i = 0; i < 3; i++) begin
          logic ed;
          ed = m_active[i] && (cyc - m_start[i] == lat_of(i) + 1) && !m_pulse[1];
          chk($sformatf("cycle%0d_dut%0d", cyc, i),
              {alu_a[i], alu_b[i], alu_op[i], led[i], busy[i], done[i]},
              {m_acc[i], m_b[i], m_op[i], m_acc[i][15:0], m_active[i], ed});
          if (done[i]) begin done_cnt[i]++; last_done[i] = cyc; end
          if (busy[i]) busy_cyc[i]++;
        end
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  int p, d0 [3], b0 [3];

  task automatic snap();
    for (int i = 0; i < 3; i++) begin d0[i] = done_cnt[i]; b0[i] = busy_cyc[i]; end
  endtask

  initial begin
    resetn = 1'b0; btnd = 1'b0; btnu = 1'b0; sw = '0; alu_op_in = '0;
    cycles(3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outputs_dut%0d", i), {alu_a[i], alu_b[i], alu_op[i], led[i], busy[i], done[i]}, '0);
    resetn = 1'b1;
    cycles(5);

    // add 0 + 5, button held 20 clocks
    sw = 16'h0005; alu_op_in = 4'b0010;
    snap(); p = cyc; btnd = 1'b1; cycles(20); btnd = 1'b0; cycles(20);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("add_one_done_dut%0d", i), done_cnt[i] - d0[i], 1);
      chk($sformatf("add_latency_dut%0d", i), last_done[i] - p, lat_exp[i]);
    end
    chk("add_acc", alu_a[0], 32'h00000005);
    chk("add_led", led[0], 16'h0005);

    // sign extension: 5 + (-1)
    sw = 16'hFFFF;
    btnd = 1'b1; cycles(20); btnd = 1'b0; cycles(20);
    chk("sext_alu_b", alu_b[0], 32'hFFFFFFFF);
    chk("sext_acc", alu_a[0], 32'h00000004);
    chk("sext_led", led[2], 16'h0004);

    // 3-clock glitches are filtered
    sw = 16'h0002; snap();
    repeat (4) begin btnd = 1'b1; cycles(3); btnd = 1'b0; cycles(5); end
    cycles(10);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("glitch_no_busy_dut%0d", i), busy_cyc[i] - b0[i], 0);
      chk($sformatf("glitch_no_done_dut%0d", i), done_cnt[i] - d0[i], 0);
    end

    // bouncing press that settles high
    snap();
    btnd = 1'b1; cycles(1); btnd = 1'b0; cycles(1); btnd = 1'b1; cycles(2);
    btnd = 1'b0; cycles(1); btnd = 1'b1; cycles(20); btnd = 1'b0; cycles(20);
    for (int i = 0; i < 3; i++) chk($sformatf("bounce_one_done_dut%0d", i), done_cnt[i] - d0[i], 1);
    chk("bounce_acc", alu_a[0], 32'h00000006);

    // short release/repress while the long-latency op is in flight
    sw = 16'h0003; snap(); p = cyc;
    btnd = 1'b1; cycles(9); btnd = 1'b0; cycles(2); btnd = 1'b1; cycles(20); btnd = 1'b0; cycles(20);
    chk("busy_drop_one_done", done_cnt[1] - d0[1], 1);
    chk("busy_drop_latency", last_done[1] - p, 12);
    chk("lat0_latency", last_done[2] - p, 9);
    chk("busy_drop_acc", alu_a[1], 32'h00000009);

    // clear lands mid-operation on every instance
    sw = 16'h0001; snap();
    btnd = 1'b1; cycles(2); btnu = 1'b1; cycles(20); btnd = 1'b0; btnu = 1'b0; cycles(20);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("clr_abort_no_done_dut%0d", i), done_cnt[i] - d0[i], 0);
      chk($sformatf("clr_abort_acc_dut%0d", i), alu_a[i], 32'h0);
      chk($sformatf("clr_abort_idle_dut%0d", i), busy[i], 1'b0);
    end

    // simultaneous clear and execute in IDLE
    sw = 16'h0007;
    btnd = 1'b1; cycles(20); btnd = 1'b0; cycles(20);
    chk("pre_simul_acc", alu_a[0], 32'h00000007);
    snap();
    btnd = 1'b1; btnu = 1'b1; cycles(20); btnd = 1'b0; btnu = 1'b0; cycles(20);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("simul_acc_dut%0d", i), alu_a[i], 32'h0);
      chk($sformatf("simul_no_busy_dut%0d", i), busy_cyc[i] - b0[i], 0);
    end

    // asynchronous reset while the ALU_LAT=3 instance is in WAIT
    sw = 16'h0010; snap(); p = cyc;
    btnd = 1'b1; cycles(9);
    #2 resetn = 1'b0; btnd = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("async_reset_dut%0d", i), {alu_a[i], alu_b[i], alu_op[i], led[i], busy[i], done[i]}, '0);
    cycles(3); resetn = 1'b1; cycles(15);
    chk("reset_abort_no_done_lat3", done_cnt[1] - d0[1], 0);
    chk("reset_abort_no_done_lat1", done_cnt[0] - d0[0], 0);
    for (int i = 0; i < 3; i++) chk($sformatf("post_reset_idle_dut%0d", i), busy[i], 1'b0);

    // randomized button activity, operands and opcodes
    for (int k = 0; k < 300; k++) begin
      btnd      = 1'($urandom_range(0, 1));
      btnu      = ($urandom_range(0, 7) == 0);
      sw        = 16'($urandom);
      alu_op_in = 4'($urandom);
      cycles($urandom_range(1, 12));
    end
    btnd = 1'b0; btnu = 1'b0;
    cycles(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
